// File: rtl/sys_arr_feeder.sv
// sys_arr_feeder: transmit-side front end of an MxM systolic matrix multiplier.
// Buffers A and B one row per load beat, then replays them as diagonally
// skewed, zero-flushed a/b streams under a valid/ready handshake.
// Optional macro FEEDER_DBUF_EN: ping-pong A/B banks so the next matrix pair
// loads while the current one streams, with no LOAD bubble between streams.
module sys_arr_feeder #(
    parameter int unsigned M  = 3,
    parameter int unsigned DW = 8
) (
    input  logic                 CLK,
    input  logic                 rst_n,
    input  logic                 ld_vld,
    output logic                 ld_rdy,
    input  logic [M-1:0][DW-1:0] ld_a,
    input  logic [M-1:0][DW-1:0] ld_b,
    output logic                 s_vld,
    input  logic                 s_rdy,
    output logic [M-1:0][DW-1:0] s_a,
    output logic [M-1:0][DW-1:0] s_b,
    output logic                 done
);
    localparam int unsigned L  = 3 * M - 2;
    localparam int unsigned TW = $clog2(L) + 1;
    localparam int unsigned KW = $clog2(M);
`ifdef FEEDER_DBUF_EN
    localparam int unsigned NB = 2;
`else
    localparam int unsigned NB = 1;
`endif

    typedef enum logic {LOAD = 1'b0, STREAM = 1'b1} state_t;

    state_t        state, state_d;
    logic [KW-1:0] k, k_d;
    logic [TW-1:0] t, t_d;
    logic          ld_rdy_d, s_vld_d, done_d;
    logic          ld_xfer, s_xfer, ld_last, s_last;
    logic          sbank, lbank;

    // Row storage: mem_a[bank][k] = row k of A, mem_b[bank][k] = row k of B
    logic [M-1:0][DW-1:0] mem_a [NB][M];
    logic [M-1:0][DW-1:0] mem_b [NB][M];

    assign ld_xfer = ld_vld && ld_rdy;
    assign s_xfer  = s_vld && s_rdy;
    assign ld_last = ld_xfer && (k == KW'(M - 1));
    assign s_last  = s_xfer && (t == TW'(L - 1));

`ifdef FEEDER_DBUF_EN
    logic          sbank_d, lbank_d;
    logic [NB-1:0] full, full_d;
`else
    assign sbank = 1'b0;
    assign lbank = 1'b0;
`endif

    // Next-state, counter and registered-output decode
    always_comb begin
        state_d  = state;
        k_d      = k;
        t_d      = t;
        done_d   = s_last;
        ld_rdy_d = 1'b0;
        s_vld_d  = 1'b0;
        if (ld_xfer) k_d = ld_last ? '0 : k + KW'(1);
        if (s_xfer)  t_d = s_last ? '0 : t + TW'(1);
`ifdef FEEDER_DBUF_EN
        full_d  = full;
        sbank_d = sbank;
        lbank_d = lbank;
        if (ld_last) begin
            full_d[lbank] = 1'b1;
            lbank_d       = ~lbank;
        end
        case (state)
            LOAD: begin
                if (ld_last) begin
                    state_d = STREAM;
                    sbank_d = lbank;
                    t_d     = '0;
                end
            end
            STREAM: begin
                if (s_last) begin
                    full_d[sbank] = 1'b0;
                    if (full_d[~sbank]) sbank_d = ~sbank;
                    else                state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
        ld_rdy_d = !full_d[lbank_d];
`else
        case (state)
            LOAD: begin
                if (ld_last) begin
                    state_d = STREAM;
                    t_d     = '0;
                end
            end
            STREAM: begin
                if (s_last) state_d = LOAD;
            end
            default: state_d = LOAD;
        endcase
        ld_rdy_d = (state_d == LOAD);
`endif
        s_vld_d = (state_d == STREAM);
    end

    // State, counters and handshake outputs
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state  <= LOAD;
            k      <= '0;
            t      <= '0;
            ld_rdy <= 1'b0;
            s_vld  <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_d;
            k      <= k_d;
            t      <= t_d;
            ld_rdy <= ld_rdy_d;
            s_vld  <= s_vld_d;
            done   <= done_d;
        end
    end

`ifdef FEEDER_DBUF_EN
    // Bank pointers and per-bank loaded flags
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            sbank <= 1'b0;
            lbank <= 1'b0;
            full  <= '0;
        end else begin
            sbank <= sbank_d;
            lbank <= lbank_d;
            full  <= full_d;
        end
    end
`endif

    for (genvar b = 0; b < NB; b++) begin : g_bank
        for (genvar r = 0; r < M; r++) begin : g_row
            // Capture one A/B row on its load transfer
            always_ff @(posedge CLK or negedge rst_n) begin
                if (!rst_n) begin
                    mem_a[b][r] <= '0;
                    mem_b[b][r] <= '0;
                end else if (ld_xfer && (lbank == 1'(b)) && (k == KW'(r))) begin
                    mem_a[b][r] <= ld_a;
                    mem_b[b][r] <= ld_b;
                end
            end
        end
    end

    // Lane i carries A[i][t-i] and B[t-i][i] inside its diagonal window, else 0
    for (genvar i = 0; i < M; i++) begin : g_lane
        logic [KW-1:0] da;
        logic          hit;
        assign da     = KW'(t - TW'(i));
        assign hit    = s_vld && (t >= TW'(i)) && (t < TW'(i + M));
        assign s_a[i] = hit ? mem_a[sbank][i][da] : '0;
        assign s_b[i] = hit ? mem_b[sbank][da][i] : '0;
    end
endmodule

// File: doc/sys_arr_feeder.md
Name: sys_arr_feeder

Overview:
- Transmit-side front end of the MxM systolic matrix multiplier.
- Accepts operand matrices A and B one row per beat and buffers them.
- Replays them as diagonally skewed per-cycle streams a[0:M-1] and b[0:M-1] under a valid/ready handshake, in the order the PE grid consumes them.
- Zero-pads the stream so the array can flush its last accumulations.

Parameters:
- M, 3, square matrix width (M >= 2).
- DW, 8, operand element width in bits.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ld_vld  in  1  load beat valid.
- ld_rdy  out  1  load beat ready.
- ld_a  in  M x DW  row k of A, element [j] = A[k][j].
- ld_b  in  M x DW  row k of B, element [j] = B[k][j].
- s_vld  out  1  skewed stream beat valid (drives array vld_in).
- s_rdy  in  1  downstream ready (array rdy_in).
- s_a  out  M x DW  a stream; s_a[i] feeds PE row i.
- s_b  out  M x DW  b stream; s_b[j] feeds PE column j.
- done  out  1  one-cycle pulse after the last stream beat is accepted.

Behaviour:
- Reset: one clock (CLK); reset is asynchronous and active-low (rst_n). While rst_n = 0:
  - state = LOAD; row counter k = 0; beat counter t = 0.
  - Storage cleared to 0.
  - ld_rdy = 0, s_vld = 0, done = 0, s_a = s_b = all zeros.
  - ld_rdy rises in the first cycle after deassertion.
- Transfers: a load transfer is ld_vld && ld_rdy; a stream transfer is s_vld && s_rdy, both at a rising edge.
- LOAD state:
  - ld_rdy = 1, s_vld = 0.
  - Each load transfer writes ld_a into A row k and ld_b into B row k, then k++.
  - On the transfer with k = M-1: k returns to 0, t returns to 0, and the next state is STREAM.
- STREAM state:
  - s_vld = 1; ld_rdy = 0 (unless FEEDER_DBUF_EN is defined).
  - Stream length L = 3M-2 beats, t = 0..L-1.
  - s_a[i] = A[i][t-i] when 0 <= t-i <= M-1, else 0.
  - s_b[j] = B[t-j][j] when 0 <= t-j <= M-1, else 0.
  - Beats t >= 2M-1 are all-zero flush beats.
  - s_a and s_b are decoded combinationally from storage and t.
  - Hold rule: while s_vld=1 and s_rdy=0, t is frozen, so s_a and s_b stay stable. s_vld never drops mid-stream.
  - Each stream transfer does t++.
  - On the transfer with t = L-1: done = 1 in the following cycle, and the next state is LOAD.
- Counter width: t is $clog2(3M-2)+1 bits and never wraps past L-1.
- Simultaneous events: ld_vld asserted in STREAM is ignored (no write, no k change) without FEEDER_DBUF_EN.
- Reset mid-stream: an asynchronous reset aborts immediately. Outputs go to reset values, and the partial stream is discarded.
- No arithmetic is performed; elements pass unmodified at DW bits.

Optional Feature:
- Macro: FEEDER_DBUF_EN.
- Defined:
  - Two A/B banks operate ping-pong.
  - In STREAM, ld_rdy = 1 while the other bank is not yet full, so the next matrix loads concurrently.
  - On the last stream beat, if the other bank is full, the block goes directly to STREAM on that bank with t = 0. There is no LOAD bubble, and done still pulses.
  - If the other bank is not full, the block returns to LOAD and continues filling it (k is preserved).
- Undefined:
  - Single bank; load and stream are strictly alternating as above.

Test Plan:
1. Load A = [[1,2,3],[4,5,6],[7,8,9]] and B = I (M=3), s_rdy=1.
   - Required: t0 gives s_a={1,0,0}, s_b={1,0,0}.
   - t1 gives s_a={2,4,0}, s_b={0,0,0}.
   - t2 gives s_a={3,5,7}, s_b={0,1,0}.
   - t4 gives s_a={0,0,9}, s_b={0,0,1}.
   - t5 and t6 are all zeros; done pulses 1 cycle after t6; ld_rdy=1 again.
2. Same load, s_rdy toggled 1,0,0,1,... on every beat.
   - Required: s_a and s_b hold during stall cycles; the accepted sequence is identical to test 1; exactly 7 accepted beats.
3. ld_vld pulsed with gaps (idle cycles between rows).
   - Required: only rows accepted on ld_vld&&ld_rdy are stored; STREAM begins the cycle after the 3rd accepted row.
4. rst_n driven low at t=3 of a stream.
   - Required: outputs are zero immediately (async); after release the block is in LOAD with ld_rdy=1; a fresh load then streams correctly from t0.
5. ld_vld=1 throughout STREAM with the feature off.
   - Required: ld_rdy=0, stored matrices unchanged; the stream matches test 1.
6. With FEEDER_DBUF_EN, load matrix 2 during stream 1.
   - Required: stream 2 t0 follows stream 1 t6 with no idle cycle; done pulses after each stream.
